// File: rtl/sdram_port_arbiter.sv
// Purpose: arbitrates the single 8-bit SDRAM port between the ioctl loader (writes) and the cassette player (reads).
// Latency: rd_req -> mem_rd 2 cycles; mem_ready -> rd_valid 2 cycles; loader writes have absolute priority.
// Backpressure: one buffered write (extra strobes dropped, sticky wr_ovf); reads coalesce to the latest address.
// Optional: define SDRAM_ARB_TIMEOUT_EN to abort a WAIT that sees no mem_ready within TIMEOUT_CYCLES cycles.
`timescale 1ns/1ps

module sdram_port_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              reset_ni,     // asynchronous, active low
    input  logic              dl_active_i,
    input  logic              wr_stb_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ovf_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    output logic              mem_we_o,
    output logic              mem_rd_o,
    input  logic [DATA_W-1:0] mem_dout_i,
    input  logic              mem_ready_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q;
    logic                cmd_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_din_q;
    logic                mem_we_q;
    logic                mem_rd_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    // Loader holding register, cassette request latch, overflow flag
    logic                wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                wr_ovf_q,  wr_ovf_d;
    logic                dl_q;

    logic                issue_wr;
    logic                issue_rd;
    logic                tmo_hit;
    logic                wr_abort;

    // A pending write always wins; reads are held off while a download runs
    assign issue_wr = (state_q == IDLE) && wr_pend_q;
    assign issue_rd = (state_q == IDLE) && !wr_pend_q && rd_pend_q && !dl_active_i;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q;

    assign tmo_hit = (state_q == WAIT) && !mem_ready_i && (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    assign wr_abort = tmo_hit && cmd_wr_q;

    // Next-state for the request capture registers and the sticky overflow flag
    always_comb begin
        wr_pend_d = wr_pend_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        wr_ovf_d  = wr_ovf_q;

        if (issue_wr) begin
            wr_pend_d = 1'b0;
        end
        // The slot frees up on the same edge it is issued, so a strobe then is accepted
        if (wr_stb_i) begin
            if (!wr_pend_q || issue_wr) begin
                wr_pend_d = 1'b1;
                wr_addr_d = wr_addr_i;
                wr_data_d = wr_data_i;
            end
        end

        if (issue_rd) begin
            rd_pend_d = 1'b0;
        end
        // A newer request replaces an unserved one; only the latest address matters
        if (rd_req_i) begin
            rd_pend_d = 1'b1;
            rd_addr_d = rd_addr_i;
        end

        // A new download starts with a clean overflow flag; a drop in that same cycle still counts
        if (dl_active_i && !dl_q) begin
            wr_ovf_d = 1'b0;
        end
        if ((wr_stb_i && wr_pend_q && !issue_wr) || wr_abort) begin
            wr_ovf_d = 1'b1;
        end
    end

    // Request capture registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            wr_ovf_q  <= 1'b0;
            dl_q      <= 1'b0;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            wr_ovf_q  <= wr_ovf_d;
            dl_q      <= dl_active_i;
        end
    end

    // Command sequencer: one SDRAM command in flight, all port outputs registered
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            cmd_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            mem_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue_wr) begin
                        state_q    <= ISSUE;
                        cmd_wr_q   <= 1'b1;
                        mem_addr_q <= wr_addr_q;
                        mem_din_q  <= wr_data_q;
                        mem_we_q   <= 1'b1;
                    end else if (issue_rd) begin
                        state_q    <= ISSUE;
                        cmd_wr_q   <= 1'b0;
                        mem_addr_q <= rd_addr_q;
                        mem_rd_q   <= 1'b1;
                    end
                end
                // mem_ready seen here belongs to an older command and is ignored
                ISSUE: begin
                    state_q <= WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                WAIT: begin
                    if (mem_ready_i) begin
                        state_q <= DONE;
                        if (!cmd_wr_q) begin
                            rd_data_q <= mem_dout_i;
                        end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        // Give the cassette a dummy byte so it never stalls forever
                        state_q <= IDLE;
                        if (!cmd_wr_q) begin
                            rd_data_q  <= {DATA_W{1'b1}};
                            rd_valid_q <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
                    end
                end
                // rd_data was captured on the WAIT exit edge; the strobe follows it
                DONE: begin
                    state_q    <= IDLE;
                    rd_valid_q <= !cmd_wr_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ovf_o   = wr_ovf_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;
    assign mem_we_o   = mem_we_q;
    assign mem_rd_o   = mem_rd_q;
    assign busy_o     = (state_q != IDLE);

endmodule
